// File: rtl/byte_bus_pkg.sv
// Shared phase encoding for the 9-cycle byte-serial memory bus (initiator and target sides).
// Latency: n/a (constants only).
// Backpressure: n/a.
package byte_bus_pkg;

    typedef logic [3:0] phase_t;

    localparam phase_t PH_ADDR0 = 4'd0;
    localparam phase_t PH_ADDR1 = 4'd1;
    localparam phase_t PH_ADDR2 = 4'd2;
    localparam phase_t PH_ADDR3 = 4'd3;
    localparam phase_t PH_WE    = 4'd4;
    localparam phase_t PH_DAT0  = 4'd5;
    localparam phase_t PH_DAT1  = 4'd6;
    localparam phase_t PH_DAT2  = 4'd7;
    localparam phase_t PH_DAT3  = 4'd8;
    localparam phase_t PH_IDLE  = 4'd15;

    localparam int FRAME_LEN = 9;
    localparam int WE_BIT    = 0;

endpackage

// File: rtl/bb_word_mem.sv
// DEPTH x 32 register file, cleared by reset; one synchronous write port, one combinational read port.
// Latency: read is combinational, write lands on the clock edge with wr_en high.
// Backpressure: none, always accepts.
module bb_word_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [31:0]              rd_dat
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/byte_bus_mem_responder.sv
// Target end of the byte-serial bus: deserialises address/we, serves reads byte-wise or commits writes.
// Latency: read byte 0 appears in cycle 5 (registered at the edge ending cycle 4); write commits at the edge ending cycle 8.
// Backpressure: none; frames have fixed timing and a new frame pulse aborts the one in flight.
module byte_bus_mem_responder
    import byte_bus_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MISS_DATA = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame,
    input  logic [7:0] bus_a,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic       busy,
    output logic       acc_err,
    output logic       wr_commit
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    phase_t      ph;
    phase_t      cur_p;
    phase_t      ph_nxt;
    logic        last_dat;
    logic [31:0] addr;
    logic        we;
    logic [23:0] rd_hi;
    logic [23:0] wr_word;
    logic [31:0] off;
    logic        hit;
    logic [IW-1:0] idx;
    logic [31:0] mem_rd;
    logic [31:0] rd_src;
    logic        mem_we;

    // A frame pulse always makes the current cycle phase 0, which also covers aborts.
    always_comb begin
        cur_p  = frame ? PH_ADDR0 : ph;
        ph_nxt = PH_IDLE;
        if (cur_p < PH_DAT3) begin
            ph_nxt = cur_p + 4'd1;
        end
    end

    always_comb begin
        off    = addr - BASE_ADDR;
        hit    = off < SPAN;
        idx    = off[IW+1:2];
        rd_src = hit ? mem_rd : MISS_DATA;
        mem_we = (cur_p == PH_DAT3) && we && hit;
    end

    // Busy only drops when a frame starts from idle; a back-to-back or aborting frame keeps it high.
    assign busy = (ph != PH_IDLE) || (frame && last_dat);

    bb_word_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (mem_we),
        .wr_idx (idx),
        .wr_dat ({bus_din, wr_word}),
        .rd_idx (idx),
        .rd_dat (mem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= PH_IDLE;
            last_dat  <= 1'b0;
            addr      <= '0;
            we        <= 1'b0;
            rd_hi     <= '0;
            wr_word   <= '0;
            bus_dout  <= '0;
            bus_oe    <= 1'b0;
            acc_err   <= 1'b0;
            wr_commit <= 1'b0;
        end else begin
            ph        <= ph_nxt;
            last_dat  <= (cur_p == PH_DAT3);
            acc_err   <= 1'b0;
            wr_commit <= mem_we;
            bus_oe    <= 1'b0;
            bus_dout  <= '0;
            case (cur_p)
                PH_ADDR0: addr[7:0]   <= bus_a;
                PH_ADDR1: addr[15:8]  <= bus_a;
                PH_ADDR2: addr[23:16] <= bus_a;
                PH_ADDR3: addr[31:24] <= bus_a;
                PH_WE: begin
                    we      <= bus_a[WE_BIT];
                    acc_err <= ~hit;
                    if (!bus_a[WE_BIT]) begin
                        rd_hi    <= rd_src[31:8];
                        bus_dout <= rd_src[7:0];
                        bus_oe   <= 1'b1;
                    end
                end
                PH_DAT0: begin
                    if (we) begin
                        wr_word[7:0] <= bus_din;
                    end else begin
                        bus_dout <= rd_hi[7:0];
                        bus_oe   <= 1'b1;
                    end
                end
                PH_DAT1: begin
                    if (we) begin
                        wr_word[15:8] <= bus_din;
                    end else begin
                        bus_dout <= rd_hi[15:8];
                        bus_oe   <= 1'b1;
                    end
                end
                PH_DAT2: begin
                    if (we) begin
                        wr_word[23:16] <= bus_din;
                    end else begin
                        bus_dout <= rd_hi[23:16];
                        bus_oe   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_bus_mem_responder.sv
// Scoreboarded bench: frame tasks push timed expectations, a negedge monitor pops and compares.
module tb_byte_bus_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] MISS  = 32'hDEAD_BEEF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame;
    logic [7:0] bus_a;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic       busy;
    logic       acc_err;
    logic       wr_commit;

    byte_bus_mem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .MISS_DATA (MISS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame     (frame),
        .bus_a     (bus_a),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_oe    (bus_oe),
        .busy      (busy),
        .acc_err   (acc_err),
        .wr_commit (wr_commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_byte_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_byte_t   byte_q[$];
    int          err_q[$];
    int          commit_q[$];
    bit          busy_exp[int];
    logic [31:0] mem_model [DEPTH];
    bit          in_frame_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: all timed expectations are matched against the cycle they were predicted for.
    always @(negedge clk) begin
        while (byte_q.size() > 0 && byte_q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL read_byte_missing: bus_oe never showed byte %h due cycle %0d", byte_q[0].val, byte_q[0].cyc);
            void'(byte_q.pop_front());
        end
        if (byte_q.size() > 0 && byte_q[0].cyc == cyc) begin
            exp_byte_t e;
            e = byte_q.pop_front();
            chk("read_oe", {31'd0, bus_oe}, 32'd1);
            chk("read_byte", {24'd0, bus_dout}, {24'd0, e.val});
        end else if (bus_oe) begin
            checks++; errors++;
            $display("FAIL oe_unexpected: bus_oe=1 dout=%h expected bus_oe=0 (cycle %0d)", bus_dout, cyc);
        end

        while (err_q.size() > 0 && err_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL acc_err_missing: got 0 expected pulse in cycle %0d", err_q[0]);
            void'(err_q.pop_front());
        end
        if (err_q.size() > 0 && err_q[0] == cyc) begin
            void'(err_q.pop_front());
            chk("acc_err_pulse", {31'd0, acc_err}, 32'd1);
        end else if (acc_err) begin
            checks++; errors++;
            $display("FAIL acc_err_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end

        while (commit_q.size() > 0 && commit_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL wr_commit_missing: got 0 expected pulse in cycle %0d", commit_q[0]);
            void'(commit_q.pop_front());
        end
        if (commit_q.size() > 0 && commit_q[0] == cyc) begin
            void'(commit_q.pop_front());
            chk("wr_commit_pulse", {31'd0, wr_commit}, 32'd1);
        end else if (wr_commit) begin
            checks++; errors++;
            $display("FAIL wr_commit_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end

        if (busy_exp.exists(cyc)) begin
            chk("busy", {31'd0, busy}, {31'd0, busy_exp[cyc]});
        end
    end

    task automatic idle_cycle();
        frame   = 1'b0;
        bus_a   = 8'($urandom);
        bus_din = 8'($urandom);
        busy_exp[cyc] = 1'b0;
        in_frame_prev = 1'b0;
        @(posedge clk); #1;
    endtask

    // abort_at = 0: full frame; otherwise the next frame's pulse lands in that phase (caller starts it).
    task automatic run_frame(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                             input int abort_at);
        int          c0;
        int          last;
        int          idx;
        logic [31:0] off;
        logic [31:0] rword;
        bit          hit;
        c0    = cyc;
        off   = addr - BASE;
        hit   = off < 32'(DEPTH * 4);
        idx   = hit ? int'(off >> 2) : 0;
        rword = hit ? mem_model[idx] : MISS;
        last  = (abort_at == 0) ? 8 : abort_at - 1;

        busy_exp[c0] = in_frame_prev;
        for (int p = 1; p <= last; p++) busy_exp[c0 + p] = 1'b1;
        if (!hit && (abort_at == 0 || abort_at >= 5)) err_q.push_back(c0 + 5);
        if (!we) begin
            for (int k = 0; k < 4; k++) begin
                if (abort_at == 0 || abort_at >= 5 + k) begin
                    byte_q.push_back('{cyc: c0 + 5 + k, val: rword[8*k +: 8]});
                end
            end
        end
        if (we && hit && abort_at == 0) commit_q.push_back(c0 + 9);

        for (int p = 0; p <= last; p++) begin
            frame   = (p == 0);
            bus_din = 8'($urandom);
            if (p < 4)       bus_a = addr[8*p +: 8];
            else if (p == 4) bus_a = {7'($urandom), we};
            else             bus_a = 8'($urandom);
            if (p >= 5 && we) bus_din = wdata[8*(p-5) +: 8];
            @(posedge clk); #1;
        end
        in_frame_prev = 1'b1;
        if (we && hit && abort_at == 0) mem_model[idx] = wdata;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          w;
        int          ab;
        bit          pending;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        rst_n = 1'b0; frame = 1'b0; bus_a = '0; bus_din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("reset_bus_dout", {24'd0, bus_dout}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_acc_err", {31'd0, acc_err}, 32'd0);
        chk("reset_wr_commit", {31'd0, wr_commit}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycle();

        // write then read back
        run_frame(32'h8, 1'b1, 32'hA1B2C3D4, 0);
        idle_cycle();
        run_frame(32'h8, 1'b0, 32'h0, 0);
        idle_cycle();

        // out-of-range read and write; word 0 must be untouched
        run_frame(32'h0, 1'b1, 32'h1357_9BDF, 0);
        idle_cycle();
        run_frame(32'h100, 1'b0, 32'h0, 0);
        idle_cycle();
        run_frame(32'h100, 1'b1, 32'h5A5A_5A5A, 0);
        idle_cycle();
        run_frame(32'h0, 1'b0, 32'h0, 0);
        idle_cycle();

        // aborted write leaves the old word in place
        run_frame(32'h4, 1'b1, 32'h1122_3344, 0);
        idle_cycle();
        run_frame(32'h4, 1'b1, 32'h5566_7788, 6);
        run_frame(32'h4, 1'b0, 32'h0, 0);
        idle_cycle();

        // back-to-back write then read of the same word
        run_frame(32'hC, 1'b1, 32'hCAFE_F00D, 0);
        run_frame(32'hC, 1'b0, 32'h0, 0);
        idle_cycle();

        // low address bits ignored
        run_frame(32'h7, 1'b0, 32'h0, 0);
        idle_cycle();

        // asynchronous reset in the middle of a read, between clock edges
        run_frame(32'h8, 1'b0, 32'h0, 6);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("midreset_bus_dout", {24'd0, bus_dout}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        byte_q.delete(); err_q.delete(); commit_q.delete(); busy_exp.delete();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        in_frame_prev = 1'b0;
        frame = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycle();
        run_frame(32'h8, 1'b0, 32'h0, 0);
        idle_cycle();

        // randomized traffic with occasional aborts and back-to-back frames
        pending = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (!pending) repeat ($urandom_range(0, 2)) idle_cycle();
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 'h7F));
            w  = 1'($urandom);
            ab = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_frame(a, w, 32'($urandom), ab);
            pending = (ab != 0);
        end
        if (pending) run_frame(32'h0, 1'b0, 32'h0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            run_frame(32'(i * 4), 1'b0, 32'h0, 0);
        end
        repeat (4) idle_cycle();

        chk("queues_drained", 32'(byte_q.size() + err_q.size() + commit_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
